// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_pkg
// Brief    : Shared types, constants and helpers for the posted-write store
//            buffer (entry layout, default depth, word-address slice).
// Revision : 1.0 - initial release
// ============================================================================
package store_buffer_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;

    // Entries carry a fixed-width word address so the struct does not depend
    // on the top-level AW parameter; narrower addresses are zero-extended.
    localparam int SB_AW_MAX = 64;

    typedef struct packed {
        logic [SB_AW_MAX-1:0] waddr;
        logic [31:0]          data;
        logic [3:0]           be;
    } sb_entry_t;

    // Word-aligned form of a byte address (byte offset cleared).
    function automatic logic [SB_AW_MAX-1:0] sb_word_addr(input logic [SB_AW_MAX-1:0] a);
        return {a[SB_AW_MAX-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_fwd_merge.sv
`default_nettype none
// ============================================================================
// Module   : sb_fwd_merge
// Brief    : Per-lane store-to-load forwarding. Each byte lane takes the byte
//            from the youngest valid entry matching the load word address
//            with that lane enabled; unmatched lanes fall back to RAM data.
// Revision : 1.0 - initial release
// ============================================================================
module sb_fwd_merge
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                   i_rd,
    input  sb_entry_t [DEPTH-1:0]  i_entries,
    input  logic [PW-1:0]          i_rd_ptr,
    input  logic [CW-1:0]          i_count,
    input  logic [SB_AW_MAX-1:0]   i_waddr,
    input  logic [31:0]            i_mem_rdata,
    output logic [31:0]            o_rd_data
);

    logic [PW-1:0] w_idx;

    // Walk entries oldest to youngest so a younger match overwrites an older one.
    always_comb begin
        o_rd_data = i_mem_rdata;
        w_idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_rd_ptr + PW'(k);
            if (i_rd && (CW'(k) < i_count) && (i_entries[w_idx].waddr == i_waddr)) begin
                for (int l = 0; l < 4; l++) begin
                    if (i_entries[w_idx].be[l]) begin
                        o_rd_data[l*8 +: 8] = i_entries[w_idx].data[l*8 +: 8];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : Posted-write store buffer between the MEM stage and a single-port
//            data RAM. Single-cycle store accept, FIFO drain under valid/ready,
//            coherent loads, full drain on fence.
//            Build option STORE_BUFFER_FWD_EN: byte-wise forwarding from
//            pending stores; without it, loads hitting a pending word stall.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWriteM,
    input  logic          MemReadM,
    input  logic [AW-1:0] ALUResultM,
    input  logic [31:0]   WriteDataM,
    input  logic [3:0]    byteEnable,
    input  logic          drain_req,
    output logic [31:0]   RD_data,
    output logic          sb_stall,
    output logic          sb_empty,
    output logic          mem_wvalid,
    input  logic          mem_wready,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wbe,
    output logic [AW-1:0] mem_raddr,
    input  logic [31:0]   mem_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t [DEPTH-1:0] r_mem;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_load_stall;
    logic [SB_AW_MAX-1:0]  w_ld_waddr;
    sb_entry_t             w_new;
    sb_entry_t             w_head;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_ld_waddr = sb_word_addr(SB_AW_MAX'(ALUResultM));

    // Full blocks a store regardless of a same-cycle pop, so stall never
    // depends on mem_wready.
    assign sb_stall = (MemWriteM & w_full) | (drain_req & ~w_empty) | w_load_stall;
    assign w_push   = MemWriteM & ~sb_stall;
    assign w_pop    = ~w_empty & mem_wready;

    assign w_new.waddr = w_ld_waddr;
    assign w_new.data  = WriteDataM;
    assign w_new.be    = byteEnable;

    assign w_head     = r_mem[r_rd_ptr];
    assign sb_empty   = w_empty;
    assign mem_wvalid = ~w_empty;
    assign mem_waddr  = AW'(w_head.waddr);
    assign mem_wdata  = w_head.data;
    assign mem_wbe    = w_head.be;
    assign mem_raddr  = {ALUResultM[AW-1:2], 2'b00};

`ifdef STORE_BUFFER_FWD_EN
    assign w_load_stall = 1'b0;

    sb_fwd_merge #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .CW    (CW)
    ) u_fwd_merge (
        .i_rd        (MemReadM),
        .i_entries   (r_mem),
        .i_rd_ptr    (r_rd_ptr),
        .i_count     (r_count),
        .i_waddr     (w_ld_waddr),
        .i_mem_rdata (mem_rdata),
        .o_rd_data   (RD_data)
    );
`else
    logic [PW-1:0] w_off;

    // A load stalls while any live entry targets the same word.
    always_comb begin
        w_load_stall = 1'b0;
        w_off        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PW'(i) - r_rd_ptr;
            if ((CW'(w_off) < r_count) && (r_mem[i].waddr == w_ld_waddr)) begin
                w_load_stall = MemReadM;
            end
        end
    end

    assign RD_data = mem_rdata;
`endif

    // Entry storage; validity is tracked by pointers and count, not here.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new;
        end
    end

    // Pointer and occupancy bookkeeping; reset discards pending stores.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Brief    : Self-checking bench for store_buffer with a queue-based model.
//            Follows STORE_BUFFER_FWD_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          MemWriteM, MemReadM, drain_req, mem_wready;
    logic [AW-1:0] ALUResultM;
    logic [31:0]   WriteDataM, mem_rdata;
    logic [3:0]    byteEnable;
    logic [31:0]   RD_data, mem_wdata;
    logic          sb_stall, sb_empty, mem_wvalid;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [3:0]    mem_wbe;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .byteEnable(byteEnable),
        .drain_req(drain_req), .RD_data(RD_data), .sb_stall(sb_stall),
        .sb_empty(sb_empty), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wbe(mem_wbe),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t mq[$];
    ent_t exp_wlog[$];
    ent_t dut_wlog[$];

    int n_chk  = 0;
    int n_pass = 0;

    logic        e_stall, e_empty;
    logic [31:0] e_rd;

    // Expected combinational outputs from the pending-store queue.
    function automatic void model_eval();
        logic hit;
        logic ldstall;
        hit     = 1'b0;
        e_empty = (mq.size() == 0);
        e_rd    = mem_rdata;
        foreach (mq[i]) begin
            if (mq[i].a == {ALUResultM[31:2], 2'b00}) begin
                hit = 1'b1;
                for (int l = 0; l < 4; l++)
                    if (mq[i].be[l]) e_rd[l*8 +: 8] = mq[i].d[l*8 +: 8];
            end
        end
`ifdef STORE_BUFFER_FWD_EN
        ldstall = 1'b0;
`else
        ldstall = MemReadM & hit;
        e_rd    = mem_rdata;
`endif
        e_stall = (MemWriteM && mq.size() == DEPTH) || (drain_req && !e_empty) || ldstall;
    endfunction

    // Advance one clock: capture the RAM write and update the model.
    task automatic tick();
        logic push, pop, dw;
        ent_t ne, de;
        #1;
        model_eval();
        push = MemWriteM && !e_stall;
        pop  = (mq.size() != 0) && mem_wready;
        ne.a = {ALUResultM[31:2], 2'b00}; ne.d = WriteDataM; ne.be = byteEnable;
        dw   = mem_wvalid && mem_wready;
        de.a = mem_waddr; de.d = mem_wdata; de.be = mem_wbe;
        @(posedge clk);
        if (pop)  exp_wlog.push_back(mq.pop_front());
        if (push) mq.push_back(ne);
        if (dw)   dut_wlog.push_back(de);
        @(negedge clk);
    endtask

    task automatic set_idle();
        MemWriteM = 0; MemReadM = 0; drain_req = 0;
        ALUResultM = '0; WriteDataM = '0; byteEnable = '0;
    endtask

    task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        MemWriteM = 1; MemReadM = 0; ALUResultM = a; WriteDataM = d; byteEnable = be;
    endtask

    task automatic drain_and_compare_logs(input string tag);
        set_idle(); mem_wready = 1;
        for (int c = 0; c < 20 && mq.size() != 0; c++) tick();
        tick();
        n_chk++;
        if (dut_wlog.size() != exp_wlog.size())
            $display("FAIL %s_wcount: got %0d writes, expected %0d", tag, dut_wlog.size(), exp_wlog.size());
        else n_pass++;
        for (int i = 0; i < exp_wlog.size() && i < dut_wlog.size(); i++) begin
            n_chk++;
            if (dut_wlog[i].a !== exp_wlog[i].a || dut_wlog[i].d !== exp_wlog[i].d || dut_wlog[i].be !== exp_wlog[i].be)
                $display("FAIL %s_write%0d: got %h/%h/%h expected %h/%h/%h", tag, i,
                         dut_wlog[i].a, dut_wlog[i].d, dut_wlog[i].be,
                         exp_wlog[i].a, exp_wlog[i].d, exp_wlog[i].be);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset = 1; set_idle(); mem_wready = 0; mem_rdata = 32'hCAFE_F00D;
        repeat (2) @(negedge clk);
        reset = 0; mq.delete();
        #1;
        n_chk++;
        if (mem_wvalid !== 1'b0 || sb_empty !== 1'b1 || sb_stall !== 1'b0 || RD_data !== 32'hCAFE_F00D)
            $display("FAIL reset_state: got wvalid=%b empty=%b stall=%b rd=%h expected 0 1 0 cafef00d",
                     mem_wvalid, sb_empty, sb_stall, RD_data);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_wlog.delete(); dut_wlog.delete();
        mem_wready = 1;
        set_store(32'h100, 32'hDEAD_BEEF, 4'hF);
        #1;
        n_chk++;
        if (sb_stall !== 1'b0 || mem_wvalid !== 1'b0)
            $display("FAIL basic_accept: got stall=%b wvalid=%b expected 0 0", sb_stall, mem_wvalid);
        else n_pass++;
        tick();
        set_idle();
        #1;
        n_chk++;
        if (mem_wvalid !== 1'b1 || mem_waddr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF || mem_wbe !== 4'hF)
            $display("FAIL basic_head: got v=%b a=%h d=%h be=%h expected 1 100 deadbeef f",
                     mem_wvalid, mem_waddr, mem_wdata, mem_wbe);
        else n_pass++;
        tick();
        #1;
        n_chk++;
        if (sb_empty !== 1'b1) $display("FAIL basic_empty: got %b expected 1", sb_empty);
        else n_pass++;
        drain_and_compare_logs("basic");
    endtask

    task automatic test_full();
        exp_wlog.delete(); dut_wlog.delete();
        mem_wready = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            set_store(32'h300 + 32'(4*i), $urandom, 4'hF);
            #1;
            n_chk++;
            if (sb_stall !== (i == DEPTH))
                $display("FAIL full_stall%0d: got %b expected %b", i, sb_stall, (i == DEPTH));
            else n_pass++;
            if (i < DEPTH) tick();
        end
        mem_wready = 1;
        #1;
        n_chk++;
        if (sb_stall !== 1'b1) $display("FAIL full_stall_pop: got %b expected 1", sb_stall);
        else n_pass++;
        tick();
        #1;
        n_chk++;
        if (sb_stall !== 1'b0) $display("FAIL full_stall_drop: got %b expected 0", sb_stall);
        else n_pass++;
        tick();
        drain_and_compare_logs("full");
    endtask

    task automatic test_forward();
        exp_wlog.delete(); dut_wlog.delete();
        mem_wready = 0;
        set_store(32'h200, 32'h0000_00AA, 4'b0001); tick();
        set_store(32'h200, 32'h0000_BB00, 4'b0010); tick();
        set_idle();
        MemReadM = 1; ALUResultM = 32'h204; mem_rdata = 32'h5566_7788;
        #1;
        n_chk++;
        if (sb_stall !== 1'b0 || RD_data !== 32'h5566_7788)
            $display("FAIL fwd_miss: got stall=%b rd=%h expected 0 55667788", sb_stall, RD_data);
        else n_pass++;
        ALUResultM = 32'h202; mem_rdata = 32'h1122_3344;
        #1;
`ifdef STORE_BUFFER_FWD_EN
        n_chk++;
        if (sb_stall !== 1'b0 || RD_data !== 32'h1122_BBAA)
            $display("FAIL fwd_merge: got stall=%b rd=%h expected 0 1122bbaa", sb_stall, RD_data);
        else n_pass++;
`else
        n_chk++;
        if (sb_stall !== 1'b1) $display("FAIL nofwd_stall0: got %b expected 1", sb_stall);
        else n_pass++;
        mem_wready = 1;
        tick();
        #1;
        n_chk++;
        if (sb_stall !== 1'b1) $display("FAIL nofwd_stall1: got %b expected 1", sb_stall);
        else n_pass++;
        tick();
        #1;
        n_chk++;
        if (sb_stall !== 1'b0 || RD_data !== 32'h1122_3344)
            $display("FAIL nofwd_release: got stall=%b rd=%h expected 0 11223344", sb_stall, RD_data);
        else n_pass++;
`endif
        drain_and_compare_logs("fwd");
    endtask

    task automatic test_drain();
        logic done;
        exp_wlog.delete(); dut_wlog.delete();
        mem_wready = 0;
        for (int i = 0; i < 3; i++) begin
            set_store(32'h400 + 32'(4*i), $urandom, 4'(i + 1)); tick();
        end
        set_idle(); drain_req = 1;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            mem_wready = (c % 2 == 0);
            #1;
            n_chk++;
            if (sb_stall !== (mq.size() != 0))
                $display("FAIL drain_stall_c%0d: got %b expected %b", c, sb_stall, (mq.size() != 0));
            else n_pass++;
            if (mq.size() == 0) done = 1'b1;
            else tick();
        end
        n_chk++;
        if (!done || sb_empty !== 1'b1)
            $display("FAIL drain_done: got done=%b empty=%b expected 1 1", done, sb_empty);
        else n_pass++;
        drain_and_compare_logs("drain");
        n_chk++;
        if (dut_wlog.size() != 3) $display("FAIL drain_count: got %0d expected 3", dut_wlog.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n;
        mem_wready = 0;
        set_store(32'h600, 32'h1234_5678, 4'hF); tick();
        set_store(32'h604, 32'h9ABC_DEF0, 4'hF); tick();
        set_idle();
        #2 reset = 1;
        #1;
        n_chk++;
        if (mem_wvalid !== 1'b0 || sb_empty !== 1'b1)
            $display("FAIL midreset_clear: got wvalid=%b empty=%b expected 0 1", mem_wvalid, sb_empty);
        else n_pass++;
        mq.delete();
        @(negedge clk);
        reset = 0; mem_wready = 1;
        n = dut_wlog.size();
        repeat (4) tick();
        n_chk++;
        if (dut_wlog.size() != n || mem_wvalid !== 1'b0)
            $display("FAIL midreset_nowrite: got %0d writes wvalid=%b expected %0d 0", dut_wlog.size(), mem_wvalid, n);
        else n_pass++;
    endtask

    task automatic test_random();
        exp_wlog.delete(); dut_wlog.delete();
        for (int c = 0; c < 400; c++) begin
            set_idle();
            mem_wready = ($urandom_range(0, 2) != 0);
            mem_rdata  = $urandom;
            drain_req  = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 2))
                0: set_store(32'h500 + 32'(4*$urandom_range(0, 3)), $urandom, 4'($urandom_range(1, 15)));
                1: begin MemReadM = 1; ALUResultM = 32'h500 + 32'($urandom_range(0, 15)); end
                default: ;
            endcase
            #1;
            model_eval();
            n_chk++;
            if (sb_stall !== e_stall || sb_empty !== e_empty || mem_wvalid !== !e_empty)
                $display("FAIL rand_ctl_c%0d: got stall=%b empty=%b wvalid=%b expected %b %b %b",
                         c, sb_stall, sb_empty, mem_wvalid, e_stall, e_empty, !e_empty);
            else n_pass++;
            n_chk++;
            if (mem_raddr !== {ALUResultM[31:2], 2'b00})
                $display("FAIL rand_raddr_c%0d: got %h expected %h", c, mem_raddr, {ALUResultM[31:2], 2'b00});
            else n_pass++;
            if (mq.size() != 0) begin
                n_chk++;
                if (mem_waddr !== mq[0].a || mem_wdata !== mq[0].d || mem_wbe !== mq[0].be)
                    $display("FAIL rand_head_c%0d: got %h/%h/%h expected %h/%h/%h", c,
                             mem_waddr, mem_wdata, mem_wbe, mq[0].a, mq[0].d, mq[0].be);
                else n_pass++;
            end
            if (MemReadM && !MemWriteM) begin
                n_chk++;
                if (RD_data !== e_rd)
                    $display("FAIL rand_rd_c%0d: got %h expected %h", c, RD_data, e_rd);
                else n_pass++;
            end
            tick();
        end
        drain_and_compare_logs("rand");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_forward();
        test_drain();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 expected earlier finish");
        $fatal(1, "bench timed out");
    end

endmodule
`default_nettype wire
